// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side bus of the PS/2 receive FIFO, plus receiver debug visibility.
// Handshake: ready is the valid flag for data; a byte is consumed on each rising clk edge where ready=1 and nextdata_n=0.
interface ps2_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic          nextdata_n;
    logic [7:0]    data;
    logic          ready;
    logic          overflow;
    logic          frame_err;
    logic [1:0]    rx_state;
    logic [AW:0]   count;

    modport master (
        input  nextdata_n,
        output data, ready, overflow, frame_err, rx_state, count
    );

    modport slave (
        output nextdata_n,
        input  data, ready, overflow, frame_err, rx_state, count
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver with parity/framing/timeout checks,
// feeding a byte FIFO popped by an active-low nextdata_n request.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_rx_fifo_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } rx_state_e;

    rx_state_e     state, state_next;
    logic [2:0]    clk_sync, dat_sync;
    logic [3:0]    bit_cnt;
    logic [10:0]   frame;
    logic [TW-1:0] to_cnt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          overflow, frame_err;
    logic          fall, bit_in, timeout, frame_ok;
    logic          sample, err_set, wr_req;
    logic          full, push, drop, pop, not_empty;

    // Data is taken from the same synchroniser stage as the clock it is qualified by.
    assign fall    = clk_sync[2] & ~clk_sync[1];
    assign bit_in  = dat_sync[1];
    assign timeout = (to_cnt == TW'(TIMEOUT_CYC - 1));

    // frame[0]=start, frame[8:1]=D0..D7, frame[9]=parity, frame[10]=stop
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

    assign not_empty = (count != '0);
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign push      = wr_req & ~full;
    assign drop      = wr_req & full;
    assign pop       = ~bus.nextdata_n & not_empty;

    assign bus.ready     = not_empty;
    assign bus.data      = not_empty ? mem[rd_ptr] : 8'h00;
    assign bus.overflow  = overflow;
    assign bus.frame_err = frame_err;
    assign bus.rx_state  = state;
    assign bus.count     = count;

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        err_set    = 1'b0;
        wr_req     = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    sample     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (fall) begin
                    sample = 1'b1;
                    if (bit_cnt == 4'd10) state_next = CHECK;
                end else if (timeout) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end
            end
            CHECK: begin
                state_next = IDLE;
                if (frame_ok) wr_req  = 1'b1;
                else          err_set = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            clk_sync  <= 3'b111;
            dat_sync  <= 3'b111;
            bit_cnt   <= 4'd0;
            frame     <= 11'd0;
            to_cnt    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[1:0], ps2_data};

            if (state_next == IDLE) bit_cnt <= 4'd0;
            else if (sample)        bit_cnt <= bit_cnt + 4'd1;

            if (sample) frame <= {bit_in, frame[10:1]};

            if (sample || state != SHIFT) to_cnt <= '0;
            else                          to_cnt <= to_cnt + TW'(1);

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);

            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase

            // A drop decided against the pre-pop full state wins over a same-cycle pop.
            if (drop)     overflow <= 1'b1;
            else if (pop) overflow <= 1'b0;

            if (err_set) frame_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr && push) mem[wr_ptr] <= frame[8:1];
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: bit-banged PS/2 frames, FIFO pops and
// scenario tasks comparing outputs against hand-computed values.
module tb_ps2_rx_fifo;
    localparam int DEPTH = 8;
    localparam int TO    = 200;
    localparam int W     = 8;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;

    logic clk = 1'b0;
    logic clr;
    logic ps2_clk;
    logic ps2_data;
    int   errors = 0;
    int   checks = 0;
    logic [W-1:0] exp_q[$];

    ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .clr      (clr),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus.master)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        bus.nextdata_n = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    // driver tasks
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_parity);
        return {1'b1, (~^b) ^ bad_parity, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (2) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (4) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_parity);
        send_bits(mk_frame(b, bad_parity), 11);
    endtask

    task automatic pop_one();
        @(negedge clk);
        bus.nextdata_n = 1'b0;
        @(negedge clk);
        bus.nextdata_n = 1'b1;
    endtask

    // scenarios
    task automatic test_reset();
        clr = 1'b1;
        bus.nextdata_n = 1'b0;
        ps2_clk  = 1'b0;
        ps2_data = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
        checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.data); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
        checks++; if (bus.rx_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", bus.rx_state, ST_IDLE); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        // pop requests on an empty FIFO must leave the pointers alone
        repeat (4) @(negedge clk);
        bus.nextdata_n = 1'b1;
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL empty_pop_count: got %0d expected 0", bus.count); end
        send_frame(8'hA5, 1'b0);
        checks++; if (bus.data !== 8'hA5) begin errors++; $display("FAIL empty_pop_data: got %h expected a5", bus.data); end
        checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL empty_pop_count1: got %0d expected 1", bus.count); end
    endtask

    task automatic test_single();
        int lat;
        logic [10:0] f;
        do_reset();
        f = mk_frame(8'h1C, 1'b0);
        send_bits(f, 10);
        @(negedge clk);
        ps2_data = f[10];
        repeat (2) @(negedge clk);
        ps2_clk = 1'b0;
        lat = 0;
        while (bus.ready !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat > 5) begin errors++; $display("FAIL single_latency: got %0d cycles expected <=5", lat); end
        checks++; if (bus.data !== 8'h1C) begin errors++; $display("FAIL single_data: got %h expected 1c", bus.data); end
        repeat (4) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL single_frame_err: got %b expected 0", bus.frame_err); end
        pop_one();
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL single_ready_after_pop: got %b expected 0", bus.ready); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp;
        do_reset();
        exp_q = {8'h1C, 8'hF0, 8'h1C};
        send_frame(8'h1C, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", bus.count); end
        for (int i = 0; i < 3; i++) begin
            exp = exp_q.pop_front();
            checks++; if (bus.data !== exp) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, bus.data, exp); end
            pop_one();
        end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_end: got %b expected 0", bus.ready); end
    endtask

    task automatic test_parity();
        do_reset();
        send_frame(8'h1C, 1'b1);
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL parity_ready: got %b expected 0", bus.ready); end
        checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL parity_frame_err: got %b expected 1", bus.frame_err); end
        send_frame(8'h32, 1'b0);
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL parity_next_ready: got %b expected 1", bus.ready); end
        checks++; if (bus.data !== 8'h32) begin errors++; $display("FAIL parity_next_data: got %h expected 32", bus.data); end
        checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL parity_sticky: got %b expected 1", bus.frame_err); end
    endtask

    task automatic test_overflow();
        logic [W-1:0] exp;
        do_reset();
        exp_q.delete();
        for (int i = 0; i <= DEPTH; i++) begin
            send_frame(8'h10 + 8'(i), 1'b0);
            if (i < DEPTH) exp_q.push_back(8'h10 + 8'(i));
        end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow); end
        checks++; if (bus.count !== 4'(DEPTH)) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", bus.count, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            exp = exp_q.pop_front();
            checks++; if (bus.data !== exp) begin errors++; $display("FAIL ovf_data%0d: got %h expected %h", i, bus.data, exp); end
            pop_one();
            if (i == 0) begin
                checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.overflow); end
            end
        end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL ovf_last_lost: got ready %b expected 0", bus.ready); end
    endtask

    task automatic test_timeout();
        do_reset();
        send_bits(mk_frame(8'h29, 1'b0), 5);
        checks++; if (bus.rx_state !== ST_SHIFT) begin errors++; $display("FAIL to_midframe_state: got %0d expected %0d", bus.rx_state, ST_SHIFT); end
        repeat (TO + 2) @(negedge clk);
        checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL to_frame_err: got %b expected 1", bus.frame_err); end
        checks++; if (bus.rx_state !== ST_IDLE) begin errors++; $display("FAIL to_state: got %0d expected %0d", bus.rx_state, ST_IDLE); end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL to_ready: got %b expected 0", bus.ready); end
        send_frame(8'h29, 1'b0);
        checks++; if (bus.data !== 8'h29) begin errors++; $display("FAIL to_next_data: got %h expected 29", bus.data); end
        checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL to_next_count: got %0d expected 1", bus.count); end
    endtask

    task automatic test_clr_mid_frame();
        do_reset();
        send_frame(8'h12, 1'b0);
        send_frame(8'h34, 1'b0);
        checks++; if (bus.count !== 4'd2) begin errors++; $display("FAIL clr_pre_count: got %0d expected 2", bus.count); end
        send_bits(mk_frame(8'h77, 1'b0), 4);
        @(negedge clk);
        clr = 1'b1;
        bus.nextdata_n = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        bus.nextdata_n = 1'b1;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL clr_ready: got %b expected 0", bus.ready); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL clr_count: got %0d expected 0", bus.count); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow: got %b expected 0", bus.overflow); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL clr_frame_err: got %b expected 0", bus.frame_err); end
        checks++; if (bus.rx_state !== ST_IDLE) begin errors++; $display("FAIL clr_state: got %0d expected %0d", bus.rx_state, ST_IDLE); end
        send_frame(8'h45, 1'b0);
        checks++; if (bus.data !== 8'h45) begin errors++; $display("FAIL clr_next_data: got %h expected 45", bus.data); end
        checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL clr_next_count: got %0d expected 1", bus.count); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL clr_next_frame_err: got %b expected 0", bus.frame_err); end
    endtask

    // sequence and report
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_overflow();
        test_timeout();
        test_clr_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, 8, number of byte entries in the receive FIFO; a power of two, 2..64.
REQ-002 Parameter TIMEOUT_CYC, 5000, clk cycles without a ps2_clk falling edge that abort a partial frame.
REQ-003 Port clk, in, 1, system clock; single clock domain; all state updates on the rising edge.
REQ-004 Port clr, in, 1, synchronous active-high reset.
REQ-005 Port ps2_clk, in, 1, raw PS/2 clock from the pin; asynchronous to clk.
REQ-006 Port ps2_data, in, 1, raw PS/2 data from the pin; asynchronous to clk.
REQ-007 Port nextdata_n, in, 1, active-low pop request from the downstream consumer.
REQ-008 Port data, out, 8, byte at the FIFO head.
REQ-009 Port ready, out, 1, FIFO non-empty.
REQ-010 Port overflow, out, 1, a completed valid frame was dropped because the FIFO was full.
REQ-011 Port frame_err, out, 1, sticky error flag: parity, start-bit, stop-bit or timeout error.

Function
REQ-012 The block SHALL pass ps2_clk and ps2_data through a 3-flop synchroniser, then detect a ps2_clk falling edge as sync[2]=1 and sync[1]=0.
REQ-013 The receiver SHALL sample ps2_data (synchronised) on each detected falling edge into an 11-bit frame: start, D0..D7 (LSB first), parity, stop.
REQ-014 The receive FSM SHALL have states IDLE, SHIFT and CHECK: IDLE->SHIFT on the first falling edge; SHIFT->CHECK after the 11th sampled bit; CHECK->IDLE after one cycle.
REQ-015 A frame SHALL be valid iff start=0, stop=1, and D0..D7 plus parity contain an odd number of ones.
REQ-016 In CHECK, a valid frame SHALL be written to the FIFO if the FIFO is not full; if the FIFO is full, the frame is dropped and overflow is set to 1.
REQ-017 In CHECK, an invalid frame SHALL be discarded, frame_err is set to 1, and the FIFO is unchanged.
REQ-018 In SHIFT, if TIMEOUT_CYC consecutive clk cycles pass with no falling edge, the FSM SHALL return to IDLE, discard the partial bits and set frame_err to 1.
REQ-019 ready SHALL equal (count != 0); data SHALL equal the FIFO head entry whenever ready=1 and is don't-care otherwise.
REQ-020 A pop SHALL occur on every rising clk edge where nextdata_n=0 and ready=1; each low cycle consumes exactly one byte.
REQ-021 nextdata_n=0 while ready=0 SHALL be ignored and SHALL NOT change the pointers.
REQ-022 Read and write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-023 When a write and a pop occur in the same cycle, both SHALL take effect and count SHALL stay unchanged.
REQ-024 Full is evaluated before that cycle's pop: a write with the FIFO full and a simultaneous pop SHALL still drop the frame and set overflow.
REQ-025 overflow SHALL clear to 0 on the cycle after any successful pop; frame_err SHALL clear only on clr.
REQ-026 Write-to-ready latency SHALL be at most 5 clk cycles after the 11th ps2_clk falling edge at the pin.

Reset
REQ-027 With clr=1 at a rising edge, the block SHALL set FSM=IDLE, bit counter=0, pointers=0, count=0, ready=0, overflow=0, frame_err=0, data=8'h00 and all synchroniser flops=1.
REQ-028 A clr asserted mid-frame SHALL discard the partial frame; after clr deasserts, reception restarts at the next start bit.
REQ-029 A clr asserted while a pop is requested SHALL take priority over the pop.

Verification
REQ-030 Send a frame with data 8'h1C and parity 0 -> ready=1, data=8'h1C within 5 clk; one nextdata_n low cycle -> ready=0.
REQ-031 Send 8'h1C, 8'hF0, 8'h1C back-to-back -> three pops return 1C, F0, 1C in order; ready=0 after the third pop.
REQ-032 Send 8'h1C with parity 1 -> ready stays 0 and frame_err=1; then a valid 8'h32 -> data=8'h32.
REQ-033 Send FIFO_DEPTH+1 valid frames with no pops -> overflow=1 and count=FIFO_DEPTH; one pop -> overflow=0; the first byte is retained and the last byte is lost.
REQ-034 Send 5 bits, then hold ps2_clk high for TIMEOUT_CYC+1 cycles -> frame_err=1 and FSM=IDLE; a following valid 8'h29 is received correctly.
REQ-035 Assert clr mid-frame with 2 bytes queued -> ready=0, overflow=0, frame_err=0; a subsequent clean frame with 8'h45 -> data=8'h45.
